// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: runs one 1-bit slice over WIDTH-bit operands, LSB first.
// Optional Zero/Ovf flag outputs are enabled by defining SERIAL_ALU_FLAGS_EN.
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    logic             is_arith;
    logic             sum_bit;
    logic             carry_out;
    logic             slice_bit;
    logic [WIDTH-1:0] next_shift;

    // The single 1-bit slice; B was already inverted at latch time for SUB.
    always_comb begin
        is_arith   = op_q[1];
        sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_out  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        case (op_q)
            OP_AND:  slice_bit = a_q[0] & b_q[0];
            OP_OR:   slice_bit = a_q[0] | b_q[0];
            default: slice_bit = sum_bit;
        endcase
        next_shift = {slice_bit, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        count_d  = count_q;
        carry_d  = carry_q;
        shift_d  = shift_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = InputA;
                    b_d     = (Op == OP_SUB) ? ~InputB : InputB;
                    op_d    = Op;
                    count_d = '0;
                    carry_d = (Op == OP_SUB);
                    shift_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    shift_d = next_shift;
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = is_arith & carry_out;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_d = next_shift;
                        cout_d   = is_arith & carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
                        zero_d   = (next_shift == '0);
                        // Overflow: carry into the MSB step differs from carry out of it.
                        ovf_d    = is_arith & (carry_q ^ carry_out);
`endif
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            shift_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign Ready  = (state_q == S_IDLE);
    assign Busy   = (state_q == S_RUN);
    assign Done   = (state_q == S_DONE);
    assign Result = result_q;
    assign Cout   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
    assign Zero   = zero_q;
    assign Ovf    = ovf_q;
`endif

endmodule
